id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 37 +++
 rtl/id_ex_stage_hazard_detect.sv | 41 ++++
 rtl/id_ex_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared opcode table and small decode helpers for the ID/EX pipeline stage.
// The stage and its hazard detector import the opcode constants from here,
// so this is the only place they are defined.
// Contents:
//   OP_RTYPE, OP_LW, OP_SW : 6-bit major opcodes
//   usesRt()               : instruction reads rt as a source operand
//   destOf()               : architectural destination register of an op
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type reads rt as its second ALU source and stores read rt as the
    // store data. Every other opcode treats rt as a destination or ignores
    // it, so rt must not create a dependency for those.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW);
    endfunction

    // Stores write no register; R-type writes rd; everything else writes rt.
    function automatic logic [4:0] destOf(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        if (op == OP_RTYPE) begin
            return rd;
        end else if (op == OP_SW) begin
            return 5'd0;
        end else begin
            return rt;
        end
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// id_ex_stage_hazard_detect
// Purely combinational load-use hazard detector. Raises hz when the
// instruction in ID needs a register that the load currently in EX has not
// yet produced.
// Ports:
//   id_valid          in  : ID holds a real instruction
//   id_op             in  : ID opcode (selects whether rt is a source)
//   id_rs, id_rt      in  : ID source register specifiers
//   ex_valid          in  : EX holds a real instruction (not a bubble)
//   ex_mem_read       in  : EX instruction is a load
//   ex_dest           in  : EX destination register
//   hz                out : load-use hazard this cycle
// ---------------------------------------------------------------------------
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    output logic       hz
);

    logic rsMatch;
    logic rtMatch;

    // A bubble in EX must never stall, so ex_valid gates the whole term.
    // Register 0 is hard-wired, so a load targeting it produces nothing to
    // wait for.
    always_comb begin
        rsMatch = (id_rs == ex_dest);
        rtMatch = usesRt(id_op) && (id_rt == ex_dest);
        hz      = id_valid && ex_valid && ex_mem_read && (ex_dest != 5'd0)
                  && (rsMatch || rtMatch);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall generation. Every clock edge
// either captures the decoded ID instruction or inserts a bubble; the stage
// latency is exactly one cycle.
// Parameters:
//   DW : datapath width (>= 17, immediate is sign-extended into it)
//   CW : width of the saturating stall counter
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   id_valid, id_op, id_func          : ID instruction valid / opcode / funct
//   id_rs, id_rt, id_rd               : ID register specifiers
//   id_a, id_b                        : register-file values for rs / rt
//   id_imm                            : 16-bit immediate
//   flush                             : taken branch resolved in EX, kill ID
//   ex_valid, ex_op, ex_func          : registered instruction for EX
//   ex_rs, ex_rt                      : registered source specifiers
//   ex_a, ex_b, ex_imm                : registered operands (imm sign-extended)
//   ex_dest                           : destination register (0 = none)
//   ex_mem_read, ex_mem_write         : load / store
//   ex_reg_write                      : writes a register
//   stall_id                          : hold PC and IF/ID this cycle
//   stall_cnt                         : saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [5:0]    id_op,
    input  logic [5:0]    id_func,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [15:0]   id_imm,
    input  logic          flush,
    output logic          ex_valid,
    output logic [5:0]    ex_op,
    output logic [5:0]    ex_func,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_dest,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_reg_write,
    output logic          stall_id,
    output logic [CW-1:0] stall_cnt
);

    logic          exValid_q,    exValid_d;
    logic [5:0]    exOp_q,       exOp_d;
    logic [5:0]    exFunc_q,     exFunc_d;
    logic [4:0]    exRs_q,       exRs_d;
    logic [4:0]    exRt_q,       exRt_d;
    logic [DW-1:0] exA_q,        exA_d;
    logic [DW-1:0] exB_q,        exB_d;
    logic [DW-1:0] exImm_q,      exImm_d;
    logic [4:0]    exDest_q,     exDest_d;
    logic          exMemRead_q,  exMemRead_d;
    logic          exMemWrite_q, exMemWrite_d;
    logic          exRegWrite_q, exRegWrite_d;
    logic [CW-1:0] stallCnt_q,   stallCnt_d;

    logic          hz;
    logic          loadBubble;
    logic [4:0]    idDest;

    // The hazard check looks at the registered EX state, so stall_id stays
    // meaningful (and reads 0) in the cycle right after reset.
    id_ex_stage_hazard_detect uHazard (
        .id_valid    (id_valid),
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (exValid_q),
        .ex_mem_read (exMemRead_q),
        .ex_dest     (exDest_q),
        .hz          (hz)
    );

    // A flush kills the ID instruction outright, so there is nothing left
    // to hold: it overrides the stall and the bubble is not counted.
    // Data fields are captured even for bubbles; only the valid and
    // control bits are forced to zero, which keeps the data path mux-free.
    always_comb begin
        stall_id     = hz && !flush;
        loadBubble   = flush || hz || !id_valid;
        idDest       = destOf(id_op, id_rt, id_rd);

        exOp_d       = id_op;
        exFunc_d     = id_func;
        exRs_d       = id_rs;
        exRt_d       = id_rt;
        exA_d        = id_a;
        exB_d        = id_b;
        exImm_d      = {{(DW-16){id_imm[15]}}, id_imm};

        exValid_d    = 1'b0;
        exDest_d     = 5'd0;
        exMemRead_d  = 1'b0;
        exMemWrite_d = 1'b0;
        exRegWrite_d = 1'b0;

        if (!loadBubble) begin
            exValid_d    = 1'b1;
            exDest_d     = idDest;
            exMemRead_d  = (id_op == OP_LW);
            exMemWrite_d = (id_op == OP_SW);
            exRegWrite_d = (idDest != 5'd0) && (id_op != OP_SW);
        end

        stallCnt_d = stallCnt_q;
        if (stall_id && (stallCnt_q != {CW{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    // Reset wipes the whole stage including any instruction that was being
    // stalled, so no bubble or stall state survives into the first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q    <= 1'b0;
            exOp_q       <= '0;
            exFunc_q     <= '0;
            exRs_q       <= '0;
            exRt_q       <= '0;
            exA_q        <= '0;
            exB_q        <= '0;
            exImm_q      <= '0;
            exDest_q     <= '0;
            exMemRead_q  <= 1'b0;
            exMemWrite_q <= 1'b0;
            exRegWrite_q <= 1'b0;
            stallCnt_q   <= '0;
        end else begin
            exValid_q    <= exValid_d;
            exOp_q       <= exOp_d;
            exFunc_q     <= exFunc_d;
            exRs_q       <= exRs_d;
            exRt_q       <= exRt_d;
            exA_q        <= exA_d;
            exB_q        <= exB_d;
            exImm_q      <= exImm_d;
            exDest_q     <= exDest_d;
            exMemRead_q  <= exMemRead_d;
            exMemWrite_q <= exMemWrite_d;
            exRegWrite_q <= exRegWrite_d;
            stallCnt_q   <= stallCnt_d;
        end
    end

    assign ex_valid     = exValid_q;
    assign ex_op        = exOp_q;
    assign ex_func      = exFunc_q;
    assign ex_rs        = exRs_q;
    assign ex_rt        = exRt_q;
    assign ex_a         = exA_q;
    assign ex_b         = exB_q;
    assign ex_imm       = exImm_q;
    assign ex_dest      = exDest_q;
    assign ex_mem_read  = exMemRead_q;
    assign ex_mem_write = exMemWrite_q;
    assign ex_reg_write = exRegWrite_q;
    assign stall_cnt    = stallCnt_q;

endmodule
